// File: rtl/sparse_ia_encoder.sv
// Dense pixel to (value, c_idx) sparse IA stream writer with tile length tracking.
// Optional macro SPARSE_ENC_THRESHOLD_EN adds i_threshold magnitude suppression.
module sparse_ia_encoder #(
  parameter int unsigned CHANNELS = 32,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_LEN  = 1200,
  localparam int unsigned CIDX_W  = $clog2(CHANNELS),
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_pix_valid,
  output logic                       o_pix_ready,
  input  logic [CHANNELS*DATA_W-1:0] i_pix_data,
  input  logic                       i_pix_last,
`ifdef SPARSE_ENC_THRESHOLD_EN
  input  logic [DATA_W-2:0]          i_threshold,
`endif
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_W-1:0]          o_data,
  output logic [CIDX_W-1:0]          o_c_idx,
  output logic                       o_eop,
  output logic [LEN_W-1:0]           o_len,
  output logic                       o_overflow,
  output logic                       o_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_e;

  state_e                     r_state, w_state_nx;
  logic [CHANNELS*DATA_W-1:0] r_pix, w_pix_nx;
  logic                       r_last, w_last_nx;
  logic [CHANNELS-1:0]        r_mask, w_mask_nx;
  logic                       r_valid, w_valid_nx;
  logic [DATA_W-1:0]          r_data, w_data_nx;
  logic [CIDX_W-1:0]          r_c_idx, w_c_idx_nx;
  logic                       r_eop, w_eop_nx;
  logic [LEN_W-1:0]           r_len, w_len_nx;
  logic                       r_overflow, w_overflow_nx;

  logic [CHANNELS-1:0]        w_in_mask;
  logic [CHANNELS-1:0]        w_mask_rem;
  logic [CHANNELS-1:0]        w_pe_mask;
  logic [CHANNELS*DATA_W-1:0] w_src_pix;
  logic [CIDX_W-1:0]          w_pe_idx;
  logic [DATA_W-1:0]          w_pe_data;
  logic                       w_pe_one;
  logic                       w_adv;
  logic                       w_load_out;

`ifdef SPARSE_ENC_THRESHOLD_EN
  // Magnitude with the most negative value clamped to the largest positive one.
  function automatic logic [DATA_W-2:0] f_mag(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] neg;
    neg = '0 - v;
    if (!v[DATA_W-1])             return v[DATA_W-2:0];
    else if (v[DATA_W-2:0] == '0) return '1;
    else                          return neg[DATA_W-2:0];
  endfunction
`endif

  always_comb begin
    w_in_mask = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
`ifdef SPARSE_ENC_THRESHOLD_EN
      w_in_mask[k] = f_mag(i_pix_data[k*DATA_W +: DATA_W]) > i_threshold;
`else
      w_in_mask[k] = (i_pix_data[k*DATA_W +: DATA_W] != '0);
`endif
    end
  end

  // Encoder looks at the fresh pixel while loading, else at the mask minus the current entry.
  always_comb begin
    w_mask_rem = r_mask & (r_mask - CHANNELS'(1));
    w_pe_mask  = (r_state == S_LOAD) ? w_in_mask : w_mask_rem;
    w_src_pix  = (r_state == S_LOAD) ? i_pix_data : r_pix;
    w_pe_one   = (w_pe_mask != '0) && ((w_pe_mask & (w_pe_mask - CHANNELS'(1))) == '0);
    w_pe_idx   = '0;
    w_pe_data  = '0;
    for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
      if (w_pe_mask[k]) begin
        w_pe_idx  = CIDX_W'(k);
        w_pe_data = w_src_pix[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_pix_nx      = r_pix;
    w_last_nx     = r_last;
    w_mask_nx     = r_mask;
    w_len_nx      = r_len;
    w_overflow_nx = r_overflow;
    w_load_out    = 1'b0;
    // An invalid entry in S_SCAN is one dropped for overflow; it retires without a handshake.
    w_adv         = r_valid ? i_ready : 1'b1;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nx    = S_LOAD;
          w_len_nx      = '0;
          w_overflow_nx = 1'b0;
        end
      end
      S_LOAD: begin
        if (i_pix_valid) begin
          w_pix_nx   = i_pix_data;
          w_last_nx  = i_pix_last;
          w_mask_nx  = w_in_mask;
          w_load_out = 1'b1;
          if (w_in_mask != '0) w_state_nx = S_SCAN;
          else if (i_pix_last) w_state_nx = S_DONE;
        end
      end
      S_SCAN: begin
        if (w_adv) begin
          w_mask_nx  = w_mask_rem;
          w_load_out = 1'b1;
          if (r_valid) w_len_nx      = r_len + LEN_W'(1);
          else         w_overflow_nx = 1'b1;
          if (w_mask_rem == '0) w_state_nx = r_last ? S_DONE : S_LOAD;
        end
      end
      S_DONE: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase

    w_valid_nx = r_valid;
    w_data_nx  = r_data;
    w_c_idx_nx = r_c_idx;
    w_eop_nx   = r_eop;
    if (w_load_out) begin
      w_valid_nx = (w_pe_mask != '0) && (w_len_nx != LEN_W'(MAX_LEN));
      w_data_nx  = w_pe_data;
      w_c_idx_nx = w_pe_idx;
      w_eop_nx   = w_pe_one;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix      <= '0;
      r_last     <= 1'b0;
      r_mask     <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_c_idx    <= '0;
      r_eop      <= 1'b0;
      r_len      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pix      <= w_pix_nx;
      r_last     <= w_last_nx;
      r_mask     <= w_mask_nx;
      r_valid    <= w_valid_nx;
      r_data     <= w_data_nx;
      r_c_idx    <= w_c_idx_nx;
      r_eop      <= w_eop_nx;
      r_len      <= w_len_nx;
      r_overflow <= w_overflow_nx;
    end
  end

  assign o_pix_ready = (r_state == S_LOAD);
  assign o_done      = (r_state == S_DONE);
  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_c_idx     = r_c_idx;
  assign o_eop       = r_eop;
  assign o_len       = r_len;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_sparse_ia_encoder.sv
// Bench for sparse_ia_encoder: directed and random tiles against a list-based sparse model.
// Build with SPARSE_ENC_THRESHOLD_EN to also exercise the threshold port.
module tb_sparse_ia_encoder;
  localparam int CH = 32;
  localparam int DW = 16;
  localparam int ML = 1200;
  localparam int CW = 5;
  localparam int LW = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_last = 1'b0;
  logic             rdy = 1'b0;
  logic [CH*DW-1:0] pix_data = '0;
  logic             pix_ready, o_valid, o_eop, o_overflow, o_done;
  logic [DW-1:0]    o_data;
  logic [CW-1:0]    o_c_idx;
  logic [LW-1:0]    o_len;
`ifdef SPARSE_ENC_THRESHOLD_EN
  logic [DW-2:0]    thr_sig = '0;
`endif

  int thr = 0;
  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] idx;
    logic          eop;
  } ent_t;

  ent_t             exp_q[$];
  logic [CH*DW-1:0] pix_mem[64];
  int               pcnt[64];

  sparse_ia_encoder dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_pix_valid (pix_valid),
    .o_pix_ready (pix_ready),
    .i_pix_data  (pix_data),
    .i_pix_last  (pix_last),
`ifdef SPARSE_ENC_THRESHOLD_EN
    .i_threshold (thr_sig),
`endif
    .o_valid     (o_valid),
    .i_ready     (rdy),
    .o_data      (o_data),
    .o_c_idx     (o_c_idx),
    .o_eop       (o_eop),
    .o_len       (o_len),
    .o_overflow  (o_overflow),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A channel survives when its clamped magnitude exceeds the threshold (0 = exact zero test).
  function automatic bit kept(input logic [DW-1:0] v, input int t);
    int iv;
    int mag;
    iv  = int'($signed(v));
    mag = (iv < 0) ? -iv : iv;
    if (mag > 32767) mag = 32767;
    return mag > t;
  endfunction

  task automatic set_ch(input int p, input int k, input logic [DW-1:0] v);
    pix_mem[p][k*DW +: DW] = v;
  endtask

  task automatic rand_pixel(input int p, input int dens);
    logic [DW-1:0] v;
    pix_mem[p] = '0;
    for (int k = 0; k < CH; k++) begin
      if ($urandom_range(0, 99) < dens) begin
        case ($urandom_range(0, 3))
          0: v = 16'h8000;
          1: begin
            v = 16'($urandom_range(0, 8));
            if ($urandom_range(0, 1) == 1) v = -v;
          end
          default: v = 16'($urandom);
        endcase
        set_ch(p, k, v);
      end
    end
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_data"}, 32'(o_data), 0);
    check({tag, "_cidx"}, 32'(o_c_idx), 0);
    check({tag, "_eop"}, 32'(o_eop), 0);
    check({tag, "_len"}, 32'(o_len), 0);
    check({tag, "_ovf"}, 32'(o_overflow), 0);
    check({tag, "_pixrdy"}, 32'(pix_ready), 0);
    check({tag, "_done"}, 32'(o_done), 0);
  endtask

  // mode 0: ready always high; 1: ready toggles; 2: random ready and pixel gaps.
  task automatic run_tile(input string name, input int npix, input int mode);
    ent_t px[$];
    ent_t e;
    logic [DW-1:0] v;
    int total, exp_len, cyc, hs, pi, last_evt;
    bit exp_ovf, exp_vnext, finished, pv, pr, pe;
    logic [DW-1:0] pd;
    logic [CW-1:0] pidx;

    exp_q.delete();
    total = 0;
    for (int p = 0; p < npix; p++) begin
      px.delete();
      for (int k = 0; k < CH; k++) begin
        v = pix_mem[p][k*DW +: DW];
        if (kept(v, thr)) px.push_back('{d: v, idx: CW'(k), eop: 1'b0});
      end
      pcnt[p] = 0;
      for (int i = 0; i < px.size(); i++) begin
        total++;
        if (exp_q.size() < ML) begin
          e     = px[i];
          e.eop = (i == px.size() - 1);
          exp_q.push_back(e);
          pcnt[p]++;
        end
      end
    end
    exp_ovf = (total > ML);
    exp_len = exp_ovf ? ML : total;
`ifdef SPARSE_ENC_THRESHOLD_EN
    thr_sig = (DW-1)'(thr);
`endif

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; hs = 0; pi = 0; last_evt = -10;
    exp_vnext = 0; finished = 0; pv = 0; pr = 0; pe = 0; pd = '0; pidx = '0;
    while (!finished && cyc < 20000) begin
      if (exp_vnext) begin
        check({name, "_first_latency"}, 32'(o_valid), 1);
        exp_vnext = 0;
      end
      if (pv && !pr) begin
        check({name, "_stall_valid"}, 32'(o_valid), 1);
        check({name, "_stall_data"}, 32'(o_data), 32'(pd));
        check({name, "_stall_cidx"}, 32'(o_c_idx), 32'(pidx));
      end else if (pv && pr && !pe && exp_q.size() > 0) begin
        check({name, "_back_to_back"}, 32'(o_valid), 1);
      end
      if (o_done) begin
        finished = 1;
        if (!exp_ovf) check({name, "_done_timing"}, cyc, last_evt + 1);
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom_range(0, 3) != 0);
      if (o_valid) check({name, "_pixrdy_in_scan"}, 32'(pix_ready), 0);
      if (o_valid && rdy) begin
        hs++;
        last_evt = cyc;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{d: 'x, idx: 'x, eop: 1'bx};
        check({name, "_data"}, 32'(o_data), 32'(e.d));
        check({name, "_cidx"}, 32'(o_c_idx), 32'(e.idx));
        check({name, "_eop"}, 32'(o_eop), 32'(e.eop));
      end
      if (pi < npix && (mode != 2 || $urandom_range(0, 1) == 1)) begin
        pix_valid = 1'b1;
        pix_data  = pix_mem[pi];
        pix_last  = (pi == npix - 1);
        if (pix_ready) begin
          exp_vnext = (pcnt[pi] > 0);
          last_evt  = cyc;
          pi++;
        end
      end else begin
        pix_valid = 1'b0;
      end
      pv = o_valid; pr = rdy; pe = o_eop; pd = o_data; pidx = o_c_idx;
      @(negedge clk);
      cyc++;
    end
    pix_valid = 1'b0;
    rdy       = 1'b0;
    check({name, "_no_timeout"}, 32'(finished), 1);
    check({name, "_done_one_cycle"}, 32'(o_done), 0);
    check({name, "_handshakes"}, hs, exp_len);
    check({name, "_len"}, 32'(o_len), exp_len);
    check({name, "_overflow"}, 32'(o_overflow), 32'(exp_ovf));
    check({name, "_model_drained"}, exp_q.size(), 0);
    check({name, "_idle_pixrdy"}, 32'(pix_ready), 0);
    @(negedge clk);
    check({name, "_len_holds"}, 32'(o_len), exp_len);
  endtask

  initial begin
    // Power-on reset.
    #1;
    reset_outputs_zero("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of a scan aborts the tile without o_done.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pix_valid = 1'b1;
    pix_last  = 1'b1;
    for (int k = 0; k < CH; k++) pix_data[k*DW +: DW] = 16'd9;
    rdy = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midscan_valid", 32'(o_valid), 1);
    check("midscan_len", 32'(o_len), 3);
    rst_n = 1'b0;
    #1;
    reset_outputs_zero("midscan_rst");
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", 32'(o_done), 0);
    end
    rst_n = 1'b1;
    rdy   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("after_rst_no_done", 32'(o_done), 0);
      check("after_rst_idle", 32'(pix_ready), 0);
    end

    // Single sparse pixel.
    pix_mem[0] = '0;
    set_ch(0, 3, 16'd5);
    set_ch(0, 17, -16'sd2);
    set_ch(0, 31, 16'd7);
    run_tile("single", 1, 0);

    // All-zero pixels.
    for (int p = 0; p < 4; p++) pix_mem[p] = '0;
    run_tile("allzero", 4, 0);

    // Dense pixel under toggling backpressure.
    for (int k = 0; k < CH; k++) set_ch(0, k, 16'd1);
    run_tile("backpressure", 1, 1);

    // Random sparse tiles with random handshakes.
    for (int t = 0; t < 6; t++) begin
      int np;
      np = $urandom_range(1, 8);
      for (int p = 0; p < np; p++) rand_pixel(p, (p % 3 == 1) ? 0 : $urandom_range(10, 70));
      run_tile("random", np, 2);
    end

    // Overflow: 38 fully dense pixels.
    for (int p = 0; p < 38; p++) begin
      for (int k = 0; k < CH; k++) begin
        logic [DW-1:0] v;
        v = 16'($urandom);
        if (v == '0) v = 16'h8000;
        set_ch(p, k, v);
      end
    end
    run_tile("overflow", 38, 0);

    // A new tile clears overflow and length.
    rand_pixel(0, 50);
    run_tile("post_overflow", 1, 2);

`ifdef SPARSE_ENC_THRESHOLD_EN
    thr = 3;
    pix_mem[0] = '0;
    set_ch(0, 0, 16'd3);
    set_ch(0, 1, -16'sd4);
    set_ch(0, 2, -16'sd3);
    set_ch(0, 5, 16'd100);
    run_tile("threshold", 1, 0);
    for (int t = 0; t < 3; t++) begin
      thr = $urandom_range(0, 6);
      for (int p = 0; p < 4; p++) rand_pixel(p, 60);
      run_tile("threshold_rand", 4, 2);
    end
    thr = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sparse_ia_encoder.md
Name: sparse_ia_encoder

Overview:
- Compresses dense activation pixels into the (value, channel-index) sparse stream consumed by the PE IA bundle. This is the writer side of the IA data/c_idx/len format.
- Accepts one pixel per handshake, holding CHANNELS signed values. Emits only the nonzero entries, in ascending channel order, one per cycle.
- Maintains the running entry count (IA len) for the current tile.
- Sits between the post-accumulation feature-map buffer and the IA buffers of the next layer.

Parameters:
- CHANNELS, 32, channels per pixel; c_idx width is $clog2(CHANNELS) = 5.
- DATA_W, 16, signed activation width.
- MAX_LEN, 1200, maximum entries per tile (matches IA buffer depth 0..1199).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; begins a tile. Ignored unless in S_IDLE.
- i_pix_valid  in  1  pixel present.
- o_pix_ready  out  1  encoder can accept a pixel.
- i_pix_data  in  CHANNELS*DATA_W  dense pixel; channel k is bits [k*DATA_W +: DATA_W].
- i_pix_last  in  1  qualifies the accepted pixel as the tile's last.
- o_valid  out  1  sparse entry present.
- i_ready  in  1  downstream accepts the entry.
- o_data  out  DATA_W  signed nonzero value.
- o_c_idx  out  $clog2(CHANNELS)  channel index of o_data.
- o_eop  out  1  entry is the last nonzero of its pixel.
- o_len  out  $clog2(MAX_LEN+1)  entries emitted this tile.
- o_overflow  out  1  sticky; tile exceeded MAX_LEN.
- o_done  out  1  one-cycle pulse at tile end.

Behaviour:
- Reset (async): state S_IDLE. All outputs 0, including o_len, o_overflow and o_pix_ready. Internal mask and pixel registers cleared.
- Reset mid-tile aborts the tile with no o_done.

FSM states:
- S_IDLE: on i_start go to S_LOAD and clear o_len and o_overflow.
- S_LOAD: o_pix_ready = 1. On i_pix_valid & o_pix_ready:
  - register the pixel and latch i_pix_last;
  - mask[k] = (channel k != 0).
  - If the mask is nonzero, go to S_SCAN.
  - Otherwise (all-zero pixel, nothing emitted) go to S_LOAD, or to S_DONE if last.
- S_SCAN: o_valid = 1.
  - o_c_idx = lowest set mask bit; o_data = that channel's value.
  - o_eop = 1 iff exactly one mask bit remains.
  - On i_ready: clear that bit and increment o_len.
  - When the final bit is consumed, go to S_LOAD, or to S_DONE if the pixel was last.
- S_DONE: o_done = 1 for one cycle, then S_IDLE. o_len holds its value until the next i_start.

Handshake and timing:
- o_valid, o_data, o_c_idx and o_eop are registered and stay stable while o_valid & !i_ready.
- First entry appears the cycle after pixel acceptance.
- Throughput is 1 entry/cycle under constant i_ready, plus 1 load cycle per pixel.
- o_pix_ready is low throughout S_SCAN; pixels are not overlapped.

Overflow:
- When o_len == MAX_LEN and another entry would be emitted, o_overflow sets (sticky) and the entry is dropped.
- Dropped entries: the mask bit is cleared without o_valid. Remaining entries of the tile are dropped at 1 per cycle.
- o_len saturates at MAX_LEN. o_done still fires.

Arithmetic:
- Zero test is an exact DATA_W compare to 0.
- o_len is an unsigned counter, never wrapping.
- The priority encoder is combinational over mask; the output register is loaded from it.

Optional Feature:
- Macro: SPARSE_ENC_THRESHOLD_EN.
- Defined: adds input port i_threshold (DATA_W-1 bits, unsigned). A channel is treated as zero when |value| <= i_threshold, with |-2^(DATA_W-1)| taken as 2^(DATA_W-1)-1. i_threshold is sampled at pixel acceptance.
- Undefined: no port; only exact zeros are removed.

Test Plan:
- Reset check: assert i_rst_n=0 during S_SCAN -> all outputs 0 the same cycle; o_done never pulses.
- Single-pixel tile: i_start, then one pixel with ch3=5, ch17=-2, ch31=7, rest 0, last=1, i_ready=1 -> entries (5,3,eop0), (-2,17,eop0), (7,31,eop1) on consecutive cycles; o_len=3; o_done the following cycle.
- All-zero pixels: 4 all-zero pixels, last on the 4th -> no o_valid; o_len=0; o_done 1 cycle after the 4th acceptance.
- Backpressure: dense pixel with all 32 channels = 1; toggle i_ready 0/1 every cycle -> o_data/o_c_idx stable while stalled; 32 entries with c_idx 0..31; o_pix_ready=0 until the last entry is taken.
- Overflow: 38 full pixels (1216 nonzeros), last on the 38th -> o_len=1200; o_overflow=1 after entry 1200; exactly 1200 o_valid&i_ready handshakes; o_done pulses.
- Threshold (SPARSE_ENC_THRESHOLD_EN): i_threshold=3; pixel ch0=3, ch1=-4, ch2=-3, ch5=100 -> entries (-4,1), (100,5) only.
